// File: rtl/mdio_phy_responder_if.sv
// mdio_phy_responder_if: CPU register bus (up_wr/up_rd strobes, up_addr, up_data_wr in; up_data_rd out) between a CPU master and the MDIO responder.
interface mdio_phy_responder_if;
  logic        up_wr;
  logic        up_rd;
  logic [31:0] up_addr;
  logic [31:0] up_data_wr;
  logic [31:0] up_data_rd;
  modport master (output up_wr, up_rd, up_addr, up_data_wr, input up_data_rd);
  modport slave (input up_wr, up_rd, up_addr, up_data_wr, output up_data_rd);
endinterface

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY-side responder with a 32x16 register file; ports up_clk/rst, up (CPU bus), mdc, mdio_io, mdio_wr_evt; MDIO_PHYID_RO_EN makes regs 2/3 read-only PHY IDs.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_MIN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CB1
) (
  input  logic                  up_clk,
  input  logic                  rst,
  mdio_phy_responder_if.slave   up,
  input  logic                  mdc,
  inout  wire                   mdio_io,
  output logic                  mdio_wr_evt
);
  typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, DATA} state_t;
  state_t      state_q, state_d;
  logic [2:0]  mdc_s_q, mdc_s_d;
  logic [1:0]  mdio_s_q, mdio_s_d;
  logic [5:0]  pre_q, pre_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_op_q, rd_op_d;
  logic        match_q, match_d;
  logic        ta_ok_q, ta_ok_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] tx_q, tx_d;
  logic        tx_act_q, tx_act_d;
  logic [4:0]  fcnt_q, fcnt_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        mdio_o_q, mdio_o_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [4:0]  last_q, last_d;
  logic        evt_q, evt_d;
  logic [31:0] rd_q, rd_d;
  logic        rise, fall, bit_in, commit, cpu_ok, mdio_ok;
  logic [15:0] sh_n;
`ifdef MDIO_PHYID_RO_EN
  function automatic logic [15:0] rd_reg(input logic [4:0] a);
    return a == 5'd2 ? PHY_ID1 : a == 5'd3 ? PHY_ID2 : regs_q[a];
  endfunction
  assign cpu_ok  = up.up_addr[4:1] != 4'b0001;
  assign mdio_ok = regad_q[4:1] != 4'b0001;
  logic unused_ok;
  assign unused_ok = ^{up.up_addr[31:6], up.up_data_wr[31:16]};
`else
  function automatic logic [15:0] rd_reg(input logic [4:0] a);
    return regs_q[a];
  endfunction
  assign cpu_ok  = 1'b1;
  assign mdio_ok = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{PHY_ID1, PHY_ID2, up.up_addr[31:6], up.up_data_wr[31:16]};
`endif
  assign rise        = mdc_s_q[1] & ~mdc_s_q[2];
  assign fall        = ~mdc_s_q[1] & mdc_s_q[2];
  assign bit_in      = mdio_s_q[1];
  assign sh_n        = {sh_q[14:0], bit_in};
  assign commit      = rise && state_q == DATA && cnt_q == 4'd15 && !rd_op_q && match_q && ta_ok_q && mdio_ok;
  assign mdio_io     = mdio_oe_q ? mdio_o_q : 1'bz;
  assign mdio_wr_evt = evt_q;
  assign up.up_data_rd = rd_q;
  always_comb begin
    mdc_s_d   = {mdc_s_q[1:0], mdc};
    mdio_s_d  = {mdio_s_q[0], mdio_io};
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    rd_op_d   = rd_op_q;
    match_d   = match_q;
    ta_ok_d   = ta_ok_q;
    sh_d      = sh_q;
    regad_d   = regad_q;
    tx_d      = tx_q;
    tx_act_d  = tx_act_q;
    fcnt_d    = fcnt_q;
    mdio_oe_d = mdio_oe_q;
    mdio_o_d  = mdio_o_q;
    regs_d    = regs_q;
    wr_cnt_d  = wr_cnt_q + {7'd0, commit};
    last_d    = commit ? regad_q : last_q;
    evt_d     = commit;
    rd_d      = !up.up_rd ? rd_q : up.up_addr[5] ? {8'd0, wr_cnt_q, 11'd0, last_q} : {16'd0, rd_reg(up.up_addr[4:0])};
    if (up.up_wr && !up.up_addr[5] && cpu_ok) regs_d[up.up_addr[4:0]] = up.up_data_wr[15:0];
    if (commit) regs_d[regad_q] = sh_n;
    if (rise) begin
      sh_d  = sh_n;
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          cnt_d   = 4'd0;
          pre_d   = bit_in ? (pre_q == 6'd63 ? pre_q : pre_q + 6'd1) : 6'd0;
          state_d = (!bit_in && int'(pre_q) >= PRE_MIN) ? ST1 : IDLE;
        end
        ST1: begin
          cnt_d   = 4'd0;
          state_d = bit_in ? OP : IDLE;
        end
        OP: if (cnt_q[0]) begin
          cnt_d   = 4'd0;
          rd_op_d = sh_n[1:0] == 2'b10;
          state_d = (sh_n[1] ^ sh_n[0]) ? PHYAD : IDLE;
        end
        PHYAD: if (cnt_q == 4'd4) begin
          cnt_d   = 4'd0;
          match_d = sh_n[4:0] == PHY_ADDR;
          state_d = REGAD;
        end
        REGAD: if (cnt_q == 4'd4) begin
          cnt_d   = 4'd0;
          regad_d = sh_n[4:0];
          state_d = TA;
          if (rd_op_q && match_q) begin
            tx_d     = rd_reg(sh_n[4:0]);
            tx_act_d = 1'b1;
            fcnt_d   = 5'd0;
          end
        end
        TA: if (cnt_q[0]) begin
          cnt_d   = 4'd0;
          ta_ok_d = sh_n[1:0] == 2'b10;
          state_d = DATA;
        end
        DATA: if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Read drive runs on its own fall count: TA Z, TA 0, 16 data bits, then release after the frame ends.
    if (fall && tx_act_q) begin
      fcnt_d = fcnt_q + 5'd1;
      if (fcnt_q == 5'd1) begin
        mdio_oe_d = 1'b1;
        mdio_o_d  = 1'b0;
      end else if (fcnt_q >= 5'd2 && fcnt_q <= 5'd17) begin
        mdio_o_d = tx_q[15];
        tx_d     = {tx_q[14:0], 1'b0};
      end else if (fcnt_q == 5'd18) begin
        mdio_oe_d = 1'b0;
        mdio_o_d  = 1'b1;
        tx_act_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge up_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mdc_s_q   <= '0;
      mdio_s_q  <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      rd_op_q   <= 1'b0;
      match_q   <= 1'b0;
      ta_ok_q   <= 1'b0;
      sh_q      <= '0;
      regad_q   <= '0;
      tx_q      <= '0;
      tx_act_q  <= 1'b0;
      fcnt_q    <= '0;
      mdio_oe_q <= 1'b0;
      mdio_o_q  <= 1'b1;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wr_cnt_q  <= '0;
      last_q    <= '0;
      evt_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mdc_s_q   <= mdc_s_d;
      mdio_s_q  <= mdio_s_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      rd_op_q   <= rd_op_d;
      match_q   <= match_d;
      ta_ok_q   <= ta_ok_d;
      sh_q      <= sh_d;
      regad_q   <= regad_d;
      tx_q      <= tx_d;
      tx_act_q  <= tx_act_d;
      fcnt_q    <= fcnt_d;
      mdio_oe_q <= mdio_oe_d;
      mdio_o_q  <= mdio_o_d;
      regs_q    <= regs_d;
      wr_cnt_q  <= wr_cnt_d;
      last_q    <= last_d;
      evt_q     <= evt_d;
      rd_q      <= rd_d;
    end
  end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- MDIO responder (PHY-side end) for IEEE 802.3 Clause 22 management frames.
- Holds a 32 x 16-bit register file. An MDIO master reads and writes it over mdc/mdio_io; the CPU preloads and inspects it through the up_* bus.
- Used as an on-board PHY emulator and as the loopback target when verifying the MDIO master.
- Entirely in the up_clk domain: mdc is oversampled.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PRE_MIN, 32, minimum consecutive preamble 1s required before a start-of-frame is accepted.
- PHY_ID1, 16'h0141, value of register 2 when MDIO_PHYID_RO_EN is defined.
- PHY_ID2, 16'h0CB1, value of register 3 when MDIO_PHYID_RO_EN is defined.

Ports:
- rst  input  1  asynchronous, active-high reset.
- up_clk  input  1  system clock; must run at least 4x the mdc frequency.
- up_wr  input  1  CPU write strobe, one cycle.
- up_rd  input  1  CPU read strobe, one cycle.
- up_addr  input  32  [4:0] selects the register; [5]=1 selects the status word; other bits ignored.
- up_data_wr  input  32  [15:0] is the register write data.
- up_data_rd  output  32  read data, registered.
- mdc  input  1  MDIO clock from the master; asynchronous to up_clk.
- mdio_io  inout  16-bit? no: 1  bidirectional MDIO data line. Driven only while mdio_oe=1, otherwise high-Z.
- mdio_wr_evt  output  1  one-cycle pulse when an MDIO write commits to the register file.

Behaviour:
- Reset state: all registers 0; up_data_rd=0; mdio_wr_evt=0; mdio_oe=0 (asynchronously); mdio_o=1; FSM=IDLE; preamble count=0.
- mdc and mdio_i each pass a 2-flop synchronizer.
- rise = mdc_s2 & !mdc_s3; fall = !mdc_s2 & mdc_s3.
- All protocol sampling occurs on rise, all driving on fall. This matches a master that updates on the falling edge.
- IDLE:
  - rise with mdio=1: increment preamble count, saturating at 63.
  - rise with mdio=0: if count>=PRE_MIN go to ST1; else clear count.
- ST1: rise expects 1 -> OP; a 0 -> IDLE with count cleared.
- OP: sample 2 bits MSB first. 2'b10 = read, 2'b01 = write; any other value -> IDLE with count cleared.
- PHYAD: sample 5 bits MSB first; match = (phyad==PHY_ADDR).
- REGAD: sample 5 bits MSB first. On the 5th rise of a matching read, snapshot the addressed register into a 16-bit shift register.
- TA, read with match:
  - first fall after REGAD: remain high-Z.
  - next fall: mdio_oe=1, mdio_o=0.
- TA, write: sample 2 bits; ta_ok = (bits==2'b10).
- TA, non-matching PHY: ignore both bits; never drive.
- DATA, read with match: on each of the next 16 falls drive shift[15], then shift left. On the fall after the 16th data bit, mdio_oe=0.
- DATA, write: sample 16 bits MSB first.
  - On the 16th rise, if match & ta_ok: write the register and pulse mdio_wr_evt the following cycle.
  - Else discard.
- After DATA: go to IDLE with count cleared. Back-to-back frames each need a full preamble.
- Snapshot semantics: read data is frozen at REGAD end. A CPU write during a frame's data phase does not alter the bits on the wire.
- CPU write: reg[up_addr[4:0]] <= up_data_wr[15:0] when up_addr[5]=0.
- Same-cycle collision: if a CPU write and an MDIO write commit to the same register in the same cycle, the MDIO write wins.
- CPU read, latency 1 cycle after up_rd:
  - up_addr[5]=0: up_data_rd = {16'd0, reg}.
  - up_addr[5]=1: up_data_rd = {8'd0, wr_count[7:0], 11'd0, last_regad[4:0]}. wr_count is committed MDIO writes, wrapping at 255.
- up_data_rd holds its value between reads.
- Reset mid-frame: mdio_oe drops immediately and the FSM restarts in IDLE. A partial write is never committed.
- mdc stopping mid-frame: the FSM holds its state. It has no timeout.

Optional Feature:
- MDIO_PHYID_RO_EN defined:
  - registers 2 and 3 read as PHY_ID1 and PHY_ID2 over both MDIO and CPU.
  - MDIO and CPU writes to them are ignored; no mdio_wr_evt and no wr_count increment.
- Undefined: registers 2 and 3 are ordinary read/write storage with reset value 0.

Test Plan:
- CPU writes reg5=16'hA5C3; master reads PHY 1, reg 5 -> TA is Z then 0; data bits 1010010111000011 on mdio_io; oe released after the 16th bit.
- Master writes PHY 1, reg 9 = 16'h1234 -> mdio_wr_evt pulses once; CPU read of addr 9 = 32'h00001234; status = {8'd0, 8'd1, 11'd0, 5'd9}.
- Master writes PHY 3 (mismatch) -> no register change, no pulse, mdio_oe stays 0 for the entire frame.
- Preamble of 31 ones then a valid frame -> frame ignored. Retry with 32 ones -> accepted.
- Reset asserted during the data phase of a read -> mdio_oe=0 within the same cycle; the next full frame works normally.
- MDIO_PHYID_RO_EN defined: master reads reg 2 -> 16'h0141; master writes reg 3 -> no pulse; reg 3 still reads 16'h0CB1.
